// File: rtl/cla_seq_wide_adder.sv
// cla_seq_wide_adder
//   Multi-cycle wide adder. A WIDTH-bit operand pair is split into N = WIDTH/CHUNK
//   slices. Each cycle one slice goes through a single CHUNK-bit carry-lookahead
//   stage, and the carry between slices is kept in a register. The result comes
//   back on a valid/ready handshake.
//
//   Parameters:
//     WIDTH - operand and sum width; must be a multiple of CHUNK and >= CHUNK
//     CHUNK - slice width added per cycle
//
//   Ports:
//     clk, rst_n     - clock (rising edge) and async active-low reset
//     in_valid       - A/B/Cin are valid
//     in_ready       - block can accept operands (decoded from state)
//     A, B, Cin      - operands and carry into bit 0
//     out_valid      - Sum/Cout hold a finished result
//     out_ready      - consumer takes the result
//     Sum, Cout      - registered A+B+Cin mod 2^WIDTH, carry out of bit WIDTH-1
//     busy           - high while adding or holding a result
//     Ovf            - two's-complement overflow, valid with out_valid
//                      (present only with CLA_SEQ_OVERFLOW_FLAG_EN defined)
//
//   Optional macro: CLA_SEQ_OVERFLOW_FLAG_EN adds the Ovf output.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | waiting for operands, in_ready=1
//   S_ADD  | one slice per cycle through the lookahead stage, N cycles
//   S_DONE | result held on Sum/Cout with out_valid=1 until out_ready

module cla_seq_wide_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
  output logic             Ovf,
`endif
  output logic             busy
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if ((WIDTH % CHUNK != 0) || (WIDTH < CHUNK)) begin : g_bad_param
    $error("cla_seq_wide_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_out_valid;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
  logic             r_ovf;
`endif

  logic [CHUNK-1:0] w_a_slc;
  logic [CHUNK-1:0] w_b_slc;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_sum_slc;

  assign w_a_slc = r_a[int'(r_idx) * CHUNK +: CHUNK];
  assign w_b_slc = r_b[int'(r_idx) * CHUNK +: CHUNK];
  assign w_g     = w_a_slc & w_b_slc;
  assign w_p     = w_a_slc ^ w_b_slc;

  // Each carry is built as a flat sum of products:
  //   c(i+1) = g_i | p_i g_(i-1) | ... | p_i..p_0 c0
  // so no carry term depends on another computed carry.
  always_comb begin
    logic w_term;
    w_term = 1'b0;
    w_c    = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < CHUNK; i++) begin
      w_term = r_carry;
      for (int k = 0; k <= i; k++) w_term = w_term & w_p[k];
      w_c[i+1] = w_term;
      for (int j = 0; j <= i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k <= i; k++) w_term = w_term & w_p[k];
        w_c[i+1] = w_c[i+1] | w_term;
      end
    end
  end

  assign w_sum_slc = w_p ^ w_c[CHUNK-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_idx   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_sum[int'(r_idx) * CHUNK +: CHUNK] <= w_sum_slc;
          r_carry <= w_c[CHUNK];
          r_idx   <= r_idx + IDXW'(1);
          if (r_idx == LAST_IDX) begin
            r_cout      <= w_c[CHUNK];
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
            // carry into the MSB differs from carry out of it -> signed overflow
            r_ovf       <= w_c[CHUNK] ^ w_c[CHUNK-1];
`endif
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign Sum       = r_sum;
  assign Cout      = r_cout;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
  assign Ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_cla_seq_wide_adder.sv
module tb_cla_seq_wide_adder;

  localparam int W = 16;
  localparam int C = 4;
  localparam int N = W / C;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int n_vec;
  int n_err;

  cla_seq_wide_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_in),
    .B         (b_in),
    .Cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (sum),
    .Cout      (cout),
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    .Ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  // Called at a negedge with the DUT idle. hold = cycles of backpressure in DONE.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int hold);
    logic [W-1:0] e_sum;
    logic         e_co;
    logic         e_ov;
    logic [W-1:0] mask;
    int           cyc;
    ref_add(a, b, ci, e_sum, e_co, e_ov);
    a_in      = a;
    b_in      = b;
    cin       = ci;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check_val("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    cin      = 1'($urandom);
    check_val("busy_add", 32'(busy), 32'd1);
    cyc = 0;
    while (!out_valid && cyc <= 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      // after k ADD cycles the low k slices already hold the final bits
      if (cyc <= N) begin
        mask = W'((64'd1 << (cyc * C)) - 64'd1);
        check_val("partial_sum", 32'(sum & mask), 32'(e_sum & mask));
      end
    end
    check_val("latency", 32'(cyc), 32'(N));
    check_val("sum", 32'(sum), 32'(e_sum));
    check_val("cout", 32'(cout), 32'(e_co));
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    check_val("ovf", 32'(ovf), 32'(e_ov));
`endif
    for (int i = 0; i < hold; i++) begin
      check_val("hold_valid", 32'(out_valid), 32'd1);
      check_val("hold_sum", 32'(sum), 32'(e_sum));
      check_val("hold_cout", 32'(cout), 32'(e_co));
      check_val("hold_in_ready", 32'(in_ready), 32'd0);
      in_valid = ~in_valid;
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      cin      = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("exit_valid", 32'(out_valid), 32'd0);
    check_val("exit_in_ready", 32'(in_ready), 32'd1);
    check_val("exit_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a_in      = 16'h1234;
    b_in      = 16'h4321;
    cin       = 1'b1;
    out_ready = 1'b0;

    // reset with in_valid asserted: nothing may be captured
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_sum", 32'(sum), 32'd0);
    check_val("rst_cout", 32'(cout), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    check_val("rst_ovf", 32'(ovf), 32'd0);
`endif
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", 32'(busy), 32'd0);

    run_txn(16'h1234, 16'h4321, 1'b0, 0);
    run_txn(16'hFFFF, 16'h0000, 1'b1, 0);
    run_txn(16'h8000, 16'h8000, 1'b0, 5);

    // reset in the middle of an addition
    a_in     = 16'h00FF;
    b_in     = 16'h0001;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_sum", 32'(sum), 32'd0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check_val("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_idle_valid", 32'(out_valid), 32'd0);
    run_txn(16'h0001, 16'h0001, 1'b0, 0);

`ifdef CLA_SEQ_OVERFLOW_FLAG_EN
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0);
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0);
`endif

    for (int t = 0; t < 40; t++) begin
      run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
